pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, branch and halt controller for a short in-order pipeline with a destination tracker.
// Optional feature macro: PIPE_HAZARD_FWD_EN enables operand bypassing (only load-use stalls).
module pipe_hazard_ctrl #(
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned BR_BUBBLES = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  instr_i,
  input  logic        instr_valid_i,
  input  logic        n_i,
  input  logic        z_i,
  output logic        pc_write_o,
  output logic        ir_load_o,
  output logic        bubble_o,
  output logic        pc_sel_target_o,
  output logic [2:0]  fwd_a_o,
  output logic [2:0]  fwd_b_o,
  output logic        halted_o,
  output logic [15:0] stall_cnt_o
);

  typedef enum logic [1:0] {StRun, StDrain, StBranch, StHalt} state_e;
  typedef enum logic [1:0] {BrZ, BrNz, BrPz} br_e;

  state_e                state_q, state_d;
  br_e                   br_q, br_d, br_kind;
  logic                  halt_pend_q, halt_pend_d;
  logic [2:0]            bcnt_q, bcnt_d;
  logic [15:0]           stall_cnt_q, stall_cnt_d;
  logic [DEPTH-1:0]      slot_vld_q;
  logic [DEPTH-1:0][1:0] slot_dst_q;

  logic [1:0] r1, r2, rd_a, wr_dst;
  logic       rd_a_en, rd_b_en, wr_en, is_branch, is_stop;
  logic [2:0] sel_a, sel_b;
  logic       hazard, issue, stall, taken;
  logic       pc_write, ir_load, bubble, sel_target;

  assign r1 = instr_i[7:6];
  assign r2 = instr_i[5:4];

  // Instruction decode: source A is R1 (or register 01 for ori), source B is always R2.
  always_comb begin
    rd_a_en   = 1'b0;
    rd_b_en   = 1'b0;
    rd_a      = r1;
    wr_en     = 1'b0;
    wr_dst    = r1;
    is_branch = 1'b0;
    is_stop   = 1'b0;
    br_kind   = BrZ;
    if (instr_i[2:0] == 3'b111) begin
      rd_a_en = 1'b1;
      rd_a    = 2'b01;
      wr_en   = 1'b1;
      wr_dst  = 2'b01;
    end else if (instr_i[2:0] == 3'b011) begin
      rd_a_en = 1'b1;
      wr_en   = 1'b1;
    end else begin
      case (instr_i[3:0])
        4'b0000: begin
          rd_b_en = 1'b1;
          wr_en   = 1'b1;
        end
        4'b0010: begin
          rd_a_en = 1'b1;
          rd_b_en = 1'b1;
        end
        4'b0100, 4'b0110, 4'b1000: begin
          rd_a_en = 1'b1;
          rd_b_en = 1'b1;
          wr_en   = 1'b1;
        end
        4'b0001: is_stop = 1'b1;
        4'b0101: begin
          is_branch = 1'b1;
          br_kind   = BrZ;
        end
        4'b1001: begin
          is_branch = 1'b1;
          br_kind   = BrNz;
        end
        4'b1101: begin
          is_branch = 1'b1;
          br_kind   = BrPz;
        end
        default: ;
      endcase
    end
  end

  // Youngest matching slot per source; 0 means no match, k means slot k-1.
  always_comb begin
    sel_a = 3'd0;
    sel_b = 3'd0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (sel_a == 3'd0 && rd_a_en && slot_vld_q[i] && slot_dst_q[i] == rd_a) begin
        sel_a = 3'(i + 1);
      end
      if (sel_b == 3'd0 && rd_b_en && slot_vld_q[i] && slot_dst_q[i] == r2) begin
        sel_b = 3'(i + 1);
      end
    end
  end

`ifdef PIPE_HAZARD_FWD_EN
  // Only slot 0 can produce a load-use stall, so is_load is kept for that slot alone.
  logic slot0_ld_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot0_ld_q <= 1'b0;
    end else begin
      slot0_ld_q <= issue && (instr_i[3:0] == 4'b0000);
    end
  end

  assign hazard  = slot0_ld_q && (sel_a == 3'd1 || sel_b == 3'd1);
  assign fwd_a_o = (rst_ni && issue) ? sel_a : 3'd0;
  assign fwd_b_o = (rst_ni && issue) ? sel_b : 3'd0;
`else
  assign hazard  = (sel_a != 3'd0) || (sel_b != 3'd0);
  assign fwd_a_o = 3'd0;
  assign fwd_b_o = 3'd0;
`endif

  always_comb begin
    case (br_q)
      BrZ:     taken = z_i;
      BrNz:    taken = !z_i;
      BrPz:    taken = !n_i;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    br_d        = br_q;
    halt_pend_d = halt_pend_q;
    bcnt_d      = bcnt_q;
    pc_write    = 1'b0;
    ir_load     = 1'b0;
    bubble      = 1'b0;
    sel_target  = 1'b0;
    issue       = 1'b0;
    stall       = 1'b0;
    unique case (state_q)
      StRun: begin
        if (!instr_valid_i) begin
          bubble   = 1'b1;
          pc_write = 1'b1;
          ir_load  = 1'b1;
        end else if (is_branch) begin
          bubble      = 1'b1;
          br_d        = br_kind;
          halt_pend_d = 1'b0;
          state_d     = StDrain;
        end else if (is_stop) begin
          bubble      = 1'b1;
          halt_pend_d = 1'b1;
          state_d     = StDrain;
        end else if (hazard) begin
          bubble = 1'b1;
          stall  = 1'b1;
        end else begin
          pc_write = 1'b1;
          ir_load  = 1'b1;
          issue    = 1'b1;
        end
      end
      StDrain: begin
        bubble = 1'b1;
        if (slot_vld_q == '0) begin
          bcnt_d  = 3'd0;
          state_d = halt_pend_q ? StHalt : StBranch;
        end
      end
      StBranch: begin
        bubble = 1'b1;
        if (bcnt_q == 3'(BR_BUBBLES - 1)) begin
          pc_write   = 1'b1;
          ir_load    = 1'b1;
          sel_target = taken;
          state_d    = StRun;
        end else begin
          bcnt_d = bcnt_q + 3'd1;
        end
      end
      StHalt: bubble = 1'b1;
      default: state_d = StRun;
    endcase
    stall_cnt_d = (stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StRun;
      br_q        <= BrZ;
      halt_pend_q <= 1'b0;
      bcnt_q      <= 3'd0;
      stall_cnt_q <= 16'd0;
      slot_vld_q  <= '0;
      slot_dst_q  <= '0;
    end else begin
      state_q     <= state_d;
      br_q        <= br_d;
      halt_pend_q <= halt_pend_d;
      bcnt_q      <= bcnt_d;
      stall_cnt_q <= stall_cnt_d;
      slot_vld_q  <= {slot_vld_q[DEPTH-2:0], issue && wr_en};
      slot_dst_q  <= {slot_dst_q[DEPTH-2:0], wr_dst};
    end
  end

  // Outputs are forced low while reset is held, independent of the clock.
  assign pc_write_o      = rst_ni && pc_write;
  assign ir_load_o       = rst_ni && ir_load;
  assign bubble_o        = rst_ni && bubble;
  assign pc_sel_target_o = rst_ni && sel_target;
  assign halted_o        = rst_ni && (state_q == StHalt);
  assign stall_cnt_o     = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (DEPTH=3, BR_BUBBLES=3) plus a
// DEPTH=6 instance used to drive the stall counter into saturation.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic        rst_sat_n;
  logic [7:0]  instr;
  logic        instr_valid;
  logic        n_flag;
  logic        z_flag;
  logic        pc_write, ir_load, bubble, pc_sel_target, halted;
  logic [2:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt;

  logic        s_pc_write, s_ir_load, s_bubble, s_pc_sel_target, s_halted;
  logic [2:0]  s_fwd_a, s_fwd_b;
  logic [15:0] s_stall_cnt;

  logic [4:0]  obs;
  int          tests_run = 0;
  int          fails     = 0;

  assign obs = {pc_write, ir_load, bubble, pc_sel_target, halted};

  pipe_hazard_ctrl #(
    .DEPTH      (3),
    .BR_BUBBLES (3)
  ) u_dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .instr_i         (instr),
    .instr_valid_i   (instr_valid),
    .n_i             (n_flag),
    .z_i             (z_flag),
    .pc_write_o      (pc_write),
    .ir_load_o       (ir_load),
    .bubble_o        (bubble),
    .pc_sel_target_o (pc_sel_target),
    .fwd_a_o         (fwd_a),
    .fwd_b_o         (fwd_b),
    .halted_o        (halted),
    .stall_cnt_o     (stall_cnt)
  );

  pipe_hazard_ctrl #(
    .DEPTH      (6),
    .BR_BUBBLES (3)
  ) u_sat (
    .clk_i           (clk),
    .rst_ni          (rst_sat_n),
    .instr_i         (8'h14),
    .instr_valid_i   (1'b1),
    .n_i             (1'b0),
    .z_i             (1'b0),
    .pc_write_o      (s_pc_write),
    .ir_load_o       (s_ir_load),
    .bubble_o        (s_bubble),
    .pc_sel_target_o (s_pc_sel_target),
    .fwd_a_o         (s_fwd_a),
    .fwd_b_o         (s_fwd_b),
    .halted_o        (s_halted),
    .stall_cnt_o     (s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n       = 1'b0;
    instr       = 8'h00;
    instr_valid = 1'b0;
    n_flag      = 1'b0;
    z_flag      = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    instr       = 8'h14;
    instr_valid = 1'b1;
    @(negedge clk);
    tests_run++;
    if (obs !== 5'b00000 || fwd_a !== 3'd0 || fwd_b !== 3'd0) begin
      fails++;
      $display("FAIL reset_outputs: got obs=%b fwd=%0d/%0d, expected obs=00000 fwd=0/0",
               obs, fwd_a, fwd_b);
    end
    tests_run++;
    if (stall_cnt !== 16'd0) begin
      fails++;
      $display("FAIL reset_stall_cnt: got %0d, expected 0", stall_cnt);
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (obs !== 5'b11000) begin
      fails++;
      $display("FAIL reset_first_issue: got %b, expected 11000", obs);
    end
    tick();
  endtask

  task automatic test_hazard_stall();
    apply_reset();
    instr       = 8'h14;
    instr_valid = 1'b1;
    @(negedge clk);
    tests_run++;
    if (obs !== 5'b11000) begin
      fails++;
      $display("FAIL hazard_add_issue: got %b, expected 11000", obs);
    end
    tick();
    instr = 8'h86;
`ifdef PIPE_HAZARD_FWD_EN
    @(negedge clk);
    tests_run++;
    if (obs !== 5'b11000 || fwd_b !== 3'd1 || fwd_a !== 3'd0) begin
      fails++;
      $display("FAIL hazard_bypass: got obs=%b fwd_a=%0d fwd_b=%0d, expected 11000 0 1",
               obs, fwd_a, fwd_b);
    end
    tick();
    tests_run++;
    if (stall_cnt !== 16'd0) begin
      fails++;
      $display("FAIL hazard_bypass_cnt: got %0d, expected 0", stall_cnt);
    end
`else
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests_run++;
      if (obs !== 5'b00100) begin
        fails++;
        $display("FAIL hazard_stall_cycle%0d: got %b, expected 00100", c, obs);
      end
      tick();
    end
    @(negedge clk);
    tests_run++;
    if (obs !== 5'b11000 || fwd_b !== 3'd0) begin
      fails++;
      $display("FAIL hazard_sub_issue: got obs=%b fwd_b=%0d, expected 11000 0", obs, fwd_b);
    end
    tests_run++;
    if (stall_cnt !== 16'd3) begin
      fails++;
      $display("FAIL hazard_stall_cnt: got %0d, expected 3", stall_cnt);
    end
    tick();
`endif
  endtask

  task automatic test_load_use();
    apply_reset();
    instr       = 8'h30;
    instr_valid = 1'b1;
    @(negedge clk);
    tests_run++;
    if (obs !== 5'b11000) begin
      fails++;
      $display("FAIL load_issue: got %b, expected 11000", obs);
    end
    tick();
    instr = 8'h44;
`ifdef PIPE_HAZARD_FWD_EN
    @(negedge clk);
    tests_run++;
    if (obs !== 5'b00100) begin
      fails++;
      $display("FAIL load_use_stall: got %b, expected 00100", obs);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if (obs !== 5'b11000 || fwd_b !== 3'd2 || fwd_a !== 3'd0) begin
      fails++;
      $display("FAIL load_use_issue: got obs=%b fwd_a=%0d fwd_b=%0d, expected 11000 0 2",
               obs, fwd_a, fwd_b);
    end
    tests_run++;
    if (stall_cnt !== 16'd1) begin
      fails++;
      $display("FAIL load_use_cnt: got %0d, expected 1", stall_cnt);
    end
    tick();
`else
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests_run++;
      if (obs !== 5'b00100) begin
        fails++;
        $display("FAIL load_use_stall%0d: got %b, expected 00100", c, obs);
      end
      tick();
    end
    @(negedge clk);
    tests_run++;
    if (obs !== 5'b11000 || stall_cnt !== 16'd3) begin
      fails++;
      $display("FAIL load_use_issue: got obs=%b cnt=%0d, expected 11000 3", obs, stall_cnt);
    end
    tick();
`endif
  endtask

  task automatic test_nop();
    apply_reset();
    instr       = 8'h14;
    instr_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (obs !== 5'b11100) begin
      fails++;
      $display("FAIL nop_outputs: got %b, expected 11100", obs);
    end
    tick();
    instr       = 8'h86;
    instr_valid = 1'b1;
    @(negedge clk);
    tests_run++;
    if (obs !== 5'b11000 || stall_cnt !== 16'd0) begin
      fails++;
      $display("FAIL nop_no_entry: got obs=%b cnt=%0d, expected 11000 0", obs, stall_cnt);
    end
    tick();
  endtask

  task automatic test_branch(input logic [7:0] op, input logic nf, input logic zf,
                             input logic tk, input string name);
    logic [4:0] exp;
    apply_reset();
    instr       = op;
    instr_valid = 1'b1;
    n_flag      = nf;
    z_flag      = zf;
    for (int c = 0; c < 5; c++) begin
      exp = (c == 4) ? {3'b111, tk, 1'b0} : 5'b00100;
      @(negedge clk);
      tests_run++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL %s_cycle%0d: got %b, expected %b", name, c, obs, exp);
      end
      tick();
    end
    instr = 8'h14;
    @(negedge clk);
    tests_run++;
    if (obs !== 5'b11000 || stall_cnt !== 16'd0) begin
      fails++;
      $display("FAIL %s_resume: got obs=%b cnt=%0d, expected 11000 0", name, obs, stall_cnt);
    end
    tick();
  endtask

  task automatic test_branch_behind_write();
    logic [4:0] exp;
    apply_reset();
    instr       = 8'h14;
    instr_valid = 1'b1;
    tick();
    instr  = 8'h05;
    z_flag = 1'b1;
    for (int c = 0; c < 7; c++) begin
      exp = (c == 6) ? 5'b11110 : 5'b00100;
      @(negedge clk);
      tests_run++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL br_drain_cycle%0d: got %b, expected %b", c, obs, exp);
      end
      tick();
    end
    tests_run++;
    if (stall_cnt !== 16'd0) begin
      fails++;
      $display("FAIL br_drain_cnt: got %0d, expected 0", stall_cnt);
    end
  endtask

  task automatic test_halt();
    logic [4:0] exp;
    apply_reset();
    instr_valid = 1'b1;
    instr       = 8'h30;
    tick();
    instr = 8'h70;
    @(negedge clk);
    tests_run++;
    if (obs !== 5'b11000) begin
      fails++;
      $display("FAIL halt_second_load: got %b, expected 11000", obs);
    end
    tick();
    instr = 8'h01;
    for (int c = 0; c < 24; c++) begin
      if (c == 4) instr = 8'h14;
      exp = (c < 4) ? 5'b00100 : 5'b00101;
      @(negedge clk);
      tests_run++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL halt_cycle%0d: got %b, expected %b", c, obs, exp);
      end
      tick();
    end
    tests_run++;
    if (stall_cnt !== 16'd0) begin
      fails++;
      $display("FAIL halt_cnt: got %0d, expected 0", stall_cnt);
    end
  endtask

  task automatic test_reset_abort();
    apply_reset();
    instr       = 8'h05;
    instr_valid = 1'b1;
    z_flag      = 1'b1;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (obs !== 5'b00000 || fwd_a !== 3'd0 || fwd_b !== 3'd0 || stall_cnt !== 16'd0) begin
      fails++;
      $display("FAIL abort_branch: got obs=%b fwd=%0d/%0d cnt=%0d, expected all 0",
               obs, fwd_a, fwd_b, stall_cnt);
    end
    tick();
    instr = 8'h14;
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (obs !== 5'b11000) begin
      fails++;
      $display("FAIL abort_branch_resume: got %b, expected 11000", obs);
    end
    tick();
    apply_reset();
    instr       = 8'h01;
    instr_valid = 1'b1;
    tick();
    tick();
    @(negedge clk);
    tests_run++;
    if (obs !== 5'b00101) begin
      fails++;
      $display("FAIL abort_halt_entry: got %b, expected 00101", obs);
    end
    tick();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (obs !== 5'b00000) begin
      fails++;
      $display("FAIL abort_halt: got %b, expected 00000", obs);
    end
    tick();
    instr = 8'h14;
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (obs !== 5'b11000) begin
      fails++;
      $display("FAIL abort_halt_resume: got %b, expected 11000", obs);
    end
    tick();
  endtask

  task automatic test_saturation();
`ifndef PIPE_HAZARD_FWD_EN
    // Self-dependent add on DEPTH=6: one issue then six stalls, repeating every 7 cycles.
    rst_sat_n = 1'b1;
    for (int k = 1; k <= 81900; k++) begin
      tick();
      if (k == 700) begin
        tests_run++;
        if (s_stall_cnt !== 16'd600) begin
          fails++;
          $display("FAIL sat_early: got %0d, expected 600", s_stall_cnt);
        end
      end
      if (k == 76440) begin
        tests_run++;
        if (s_stall_cnt !== 16'd65520) begin
          fails++;
          $display("FAIL sat_near: got %0d, expected 65520", s_stall_cnt);
        end
      end
      if (k == 81900) begin
        tests_run++;
        if (s_stall_cnt !== 16'hFFFF) begin
          fails++;
          $display("FAIL sat_final: got %h, expected ffff", s_stall_cnt);
        end
      end
    end
`endif
  endtask

  initial begin
    rst_n       = 1'b0;
    rst_sat_n   = 1'b0;
    instr       = 8'h00;
    instr_valid = 1'b0;
    n_flag      = 1'b0;
    z_flag      = 1'b0;
    tick();
    test_reset();
    test_hazard_stall();
    test_load_use();
    test_nop();
    test_branch(8'h05, 1'b0, 1'b1, 1'b1, "bz_taken");
    test_branch(8'h05, 1'b0, 1'b0, 1'b0, "bz_not_taken");
    test_branch(8'h09, 1'b0, 1'b0, 1'b1, "bnz_taken");
    test_branch(8'h0D, 1'b1, 1'b0, 1'b0, "bpz_not_taken");
    test_branch(8'h0D, 1'b0, 1'b1, 1'b1, "bpz_taken");
    test_branch_behind_write();
    test_halt();
    test_reset_abort();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
